// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter over 8 requesters with a one-hot grant, a done/withdraw
// handshake and a MAX_HOLD timeout that stops one requester starving the rest.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic [7:0] gnt,
  output logic       timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nx;
  logic [2:0] last, last_nx;
  logic [7:0] cnt, cnt_nx;
  logic       valid_nx, to_nx;
  logic [2:0] idx_nx;
  logic [7:0] gnt_nx;

  logic [2:0] win, cand;
  logic       found;

  // Scan last+1 .. last+8; the 3-bit add gives the 7->0 wrap for free.
  always_comb begin
    win   = last;
    cand  = last;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cand = last + 3'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    last_nx  = last;
    cnt_nx   = cnt;
    valid_nx = gnt_valid;
    idx_nx   = gnt_idx;
    gnt_nx   = gnt;
    to_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          valid_nx = 1'b1;
          idx_nx   = win;
          gnt_nx   = 8'b1 << win;
          last_nx  = win;
          cnt_nx   = '0;
        end
      end
      GRANT: begin
        // Voluntary release outranks expiry, so a coincident done gives no pulse.
        if (done || !req[gnt_idx] || cnt == HOLD_LAST) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
          gnt_nx   = 8'h00;
          to_nx    = !(done || !req[gnt_idx]);
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 3'd7;
      cnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= 3'd0;
      gnt       <= 8'h00;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      last      <= last_nx;
      cnt       <= cnt_nx;
      gnt_valid <= valid_nx;
      gnt_idx   <= idx_nx;
      gnt       <= gnt_nx;
      timeout   <= to_nx;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: expected {valid,idx,gnt,timeout} words are
// queued as stimulus is driven and popped against the DUT one step later.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic       gnt_valid, timeout;
  logic [2:0] gnt_idx;
  logic [7:0] gnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [12:0] sbq[$];
  logic inv_on = 1'b0;

  rr_arbiter_8 #(.MAX_HOLD(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .gnt(gnt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] ex(input logic v, input logic [2:0] i, input logic to);
    logic [7:0] g;
    g = v ? (8'b1 << i) : 8'h00;
    return {v, i, g, to};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // gnt holds at most one bit and is nonzero exactly while gnt_valid is high.
  always @(negedge clk) begin
    logic ok;
    if (inv_on) begin
      ok = ($countones(gnt) <= 1) && ((gnt != 8'h00) == gnt_valid);
      n_cmp++;
      if (ok !== 1'b1) begin
        n_err++;
        $display("FAIL invariant t=%0t got gnt=%h valid=%b", $time, gnt, gnt_valid);
      end
    end
  end

  task automatic test_reset;
    logic [12:0] e, o;
    rst_n = 1'b0;
    req   = 8'h00;
    for (int s = 0; s < 5; s++) begin
      if (s == 3) rst_n = 1'b1;
      sbq.push_back(ex(1'b0, 3'd0, 1'b0));
      tick();
      e = sbq.pop_front();
      o = {gnt_valid, gnt_idx, gnt, timeout};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset[%0d] got %h want %h", s, o, e);
      end
    end
    inv_on = 1'b1;
  endtask

  task automatic test_single;
    logic [7:0]  rq[7] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00};
    logic        dn[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [12:0] xp[7];
    logic [12:0] e, o;
    xp = '{ex(1, 4, 0), ex(1, 4, 0), ex(1, 4, 0), ex(0, 4, 0),
           ex(1, 4, 0), ex(1, 4, 0), ex(0, 4, 0)};
    for (int s = 0; s < 7; s++) begin
      req  = rq[s];
      done = dn[s];
      sbq.push_back(xp[s]);
      tick();
      e = sbq.pop_front();
      o = {gnt_valid, gnt_idx, gnt, timeout};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL single[%0d] got %h want %h", s, o, e);
      end
    end
    done = 1'b0;
  endtask

  task automatic test_rr_wrap;
    logic [12:0] e, o;
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 20; k++) begin
      done = k[0];
      sbq.push_back(ex(!k[0], 3'(k / 2), 1'b0));
      tick();
      e = sbq.pop_front();
      o = {gnt_valid, gnt_idx, gnt, timeout};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL rr_wrap[%0d] got %h want %h", k, o, e);
      end
    end
    done = 1'b0;
    req  = 8'h00;
    tick();
  endtask

  task automatic test_timeout;
    logic [12:0] e, o;
    do_reset();
    req = 8'h05;
    for (int s = 0; s < 19; s++) begin
      if (s < 16)       sbq.push_back(ex(1'b1, 3'd0, 1'b0));
      else if (s == 16) sbq.push_back(ex(1'b0, 3'd0, 1'b1));
      else if (s == 17) sbq.push_back(ex(1'b1, 3'd2, 1'b0));
      else begin
        req = 8'h00;
        sbq.push_back(ex(1'b0, 3'd2, 1'b0));
      end
      tick();
      e = sbq.pop_front();
      o = {gnt_valid, gnt_idx, gnt, timeout};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL timeout[%0d] got %h want %h", s, o, e);
      end
    end
  endtask

  task automatic test_coincident;
    logic [12:0] e, o;
    req = 8'h08;
    for (int s = 0; s < 24; s++) begin
      done = 1'b0;
      if (s < 16)       sbq.push_back(ex(1'b1, 3'd3, 1'b0));
      else if (s == 16) begin
        done = 1'b1;
        sbq.push_back(ex(1'b0, 3'd3, 1'b0));
      end else if (s == 17) begin
        req = 8'h00;
        sbq.push_back(ex(1'b0, 3'd3, 1'b0));
      end else if (s == 18) begin
        req = 8'h40;
        sbq.push_back(ex(1'b1, 3'd6, 1'b0));
      end else if (s == 19) begin
        req = 8'h41;
        sbq.push_back(ex(1'b1, 3'd6, 1'b0));
      end else if (s == 20) begin
        req = 8'h01;
        sbq.push_back(ex(1'b0, 3'd6, 1'b0));
      end else if (s == 21) sbq.push_back(ex(1'b1, 3'd0, 1'b0));
      else if (s == 22) begin
        req = 8'h00;
        sbq.push_back(ex(1'b0, 3'd0, 1'b0));
      end else sbq.push_back(ex(1'b0, 3'd0, 1'b0));
      tick();
      e = sbq.pop_front();
      o = {gnt_valid, gnt_idx, gnt, timeout};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL coincident[%0d] got %h want %h", s, o, e);
      end
    end
    done = 1'b0;
  endtask

  task automatic test_async_reset;
    logic [12:0] e, o;
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: begin req = 8'h08; sbq.push_back(ex(1'b1, 3'd3, 1'b0)); tick(); end
        1: begin #2; rst_n = 1'b0; #1; sbq.push_back(ex(1'b0, 3'd0, 1'b0)); end
        2: begin sbq.push_back(ex(1'b0, 3'd0, 1'b0)); tick(); end
        3: begin rst_n = 1'b1; sbq.push_back(ex(1'b1, 3'd3, 1'b0)); tick(); end
        4: begin done = 1'b1; sbq.push_back(ex(1'b0, 3'd3, 1'b0)); tick(); end
        default: begin done = 1'b0; req = 8'h00; sbq.push_back(ex(1'b0, 3'd3, 1'b0)); tick(); end
      endcase
      e = sbq.pop_front();
      o = {gnt_valid, gnt_idx, gnt, timeout};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL async_reset[%0d] got %h want %h", s, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_wrap();
    test_timeout();
    test_coincident();
    test_async_reset();
    inv_on = 1'b0;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Encodes the winner as a 3-bit index and expands it to a one-hot 8-bit grant, using the same encoding as the 3-to-8 decoder.
- Sits in front of the decoder-driven select path. It replaces free-running select stimulus with fair, handshaked sequencing of the 8 decoded lines.
- Includes a hold timeout so that one requester cannot starve the others.

Parameters:
- MAX_HOLD, 16: maximum cycles one grant may last; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  8  request vector; bit i = requester i
- done  in  1  current grantee releases the resource; sampled only while gnt_valid=1
- gnt_valid  out  1  a grant is active
- gnt_idx  out  3  index of the current grantee; holds the last value when gnt_valid=0
- gnt  out  8  one-hot grant equal to 1<<gnt_idx when gnt_valid=1, else 8'h00
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. All outputs and state are registered.
- Reset values:
  - gnt_valid=0, gnt=8'h00, gnt_idx=3'd0, timeout=0
  - last-grant pointer last=3'd7, so index 0 has top priority after reset
  - hold counter=0, state=IDLE
- rst_n low at any time, including mid-grant, clears everything immediately without waiting for clk.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, choose the first set bit scanning last+1, last+2, ... last+8 (mod 8). The index wrap 7->0 is mandatory.
  - Next edge: state=GRANT, gnt_valid=1, gnt_idx=winner, gnt=1<<winner, last=winner, counter=0.
  - Latency from req sampled in IDLE to gnt visible is 1 cycle.
  - If req==0, stay in IDLE; outputs unchanged except timeout=0.
- GRANT: counter increments each cycle. Release conditions, evaluated on each edge:
  - a) done=1 -> release, timeout=0
  - b) req[gnt_idx]=0 -> release, timeout=0 (requester withdrew)
  - c) counter==MAX_HOLD-1 with neither a nor b -> release, timeout=1 for exactly one cycle
  - Priority when events coincide: a = b > c. A done or withdraw coinciding with expiry gives no timeout pulse.
- On release: next state IDLE, gnt_valid=0, gnt=8'h00, gnt_idx retained.
  - There is exactly one dead cycle between consecutive grants. Back-to-back requesters therefore see a grant every (hold+1) cycles minimum.
- Changes to other req bits during GRANT do not affect the current grant. They are considered only in the next IDLE cycle.
- done while in IDLE is ignored.
- MAX_HOLD=1: every grant lasts exactly 1 cycle. timeout pulses unless done or withdraw occurs in that same cycle.
- Fairness: a continuously asserted requester waits at most 7 other grants before being served.
- Invariant, checked by the bench: gnt has at most one bit set, and gnt != 0 exactly when gnt_valid=1.

Test Plan:
- Reset/idle:
  - Stimulus: rst_n=0 for 3 cycles, req=8'h00, release rst_n.
  - Required: gnt=8'h00, gnt_valid=0, gnt_idx=0, timeout=0 throughout.
- Single requester:
  - Stimulus: req=8'h10, then done=1 on the 3rd grant cycle.
  - Required: gnt_valid=1 one cycle after req, gnt_idx=4, gnt=8'h10, held 3 cycles. gnt=8'h00 the cycle after done. With req still high, re-granted after the 1 dead cycle.
- Round-robin wrap:
  - Stimulus: req=8'hFF held, done pulsed on every grant's first cycle.
  - Required: gnt_idx sequence 0,1,2,...,7,0,1 with one dead cycle between each. gnt sequence 8'h01, 8'h02, ... 8'h80, 8'h01.
- Timeout:
  - Stimulus: MAX_HOLD=16, req=8'h05, done never asserted.
  - Required: idx 0 granted for exactly 16 cycles, timeout=1 on the release edge, 1 dead cycle, then idx 2 granted (pointer past 0).
- Coincident release:
  - Stimulus: done=1 on the 16th grant cycle with MAX_HOLD=16.
  - Required: release with timeout=0. Separately, dropping req[idx] mid-grant releases on the next edge.
- Async reset mid-grant:
  - Stimulus: rst_n driven low between clock edges while gnt=8'h08.
  - Required: gnt=8'h00 and gnt_valid=0 before the next edge. After release with req=8'h08, idx 3 is granted again, since last reset to 7 makes 0..3 the scan order.
